spine_output_arbiter: RTL and testbench

//  Output-port scheduler for the spine router. One instance sits in front of each router_port output side.
//  It shares that output among NUM_PORTS input requesters using round-robin arbitration.
//  A grant is locked for a whole packet, head flit through last flit, so flits of different packets never interleave.

---
 rtl/spine_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/spine_output_arbiter.sv | 124 ++++++++++++
 tb/tb_spine_output_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spine_pkg.sv
// Shared constants and state encodings for the spine router output side.
// Imported by the output arbiter and its round-robin picker.
package spine_pkg;

  localparam int NUM_PORTS = 11;
  localparam int DWIDTH    = 16;
  localparam int IDX_W     = 4;
  localparam int TIMEOUT   = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker.
// Scans ptr+1 upward with wrap-around; the first requester found wins.
module rr_arbiter #(
  parameter int NUM_PORTS = spine_pkg::NUM_PORTS,
  parameter int IDX_W     = spine_pkg::IDX_W
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 any
);

  // first valid index after ptr, wrapping through ptr itself
  always_comb begin
    int j;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      j = (int'(ptr) + k) % NUM_PORTS;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/spine_output_arbiter.sv
// Output-port scheduler: packet-locked round-robin among input requesters,
// with backpressure from the output FIFO and a mid-packet idle watchdog.
module spine_output_arbiter #(
  parameter int NUM_PORTS = spine_pkg::NUM_PORTS,
  parameter int DWIDTH    = spine_pkg::DWIDTH,
  parameter int IDX_W     = spine_pkg::IDX_W,
  parameter int TIMEOUT   = spine_pkg::TIMEOUT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_last,
  input  logic [NUM_PORTS*DWIDTH-1:0] req_data,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic                        out_fifo_full,
  output logic [DWIDTH-1:0]           out_data,
  output logic                        out_valid,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        busy,
  output logic                        timeout_err
);

  import spine_pkg::*;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_PORTS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [WD_W-1:0]   wd_cnt;

  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  logic              xfer;
  logic              grant;
  logic              sel_valid;
  logic              sel_last;
  logic [DWIDTH-1:0] sel_data;
  logic              fire;
  logic              wd_inc;
  logic              wd_trip;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt_idx (win_idx),
    .any     (win_any)
  );

  assign xfer  = (state == ST_XFER);
  assign grant = (state == ST_IDLE) && win_any;
  assign busy  = xfer;

  // select the owner's valid/last/data from the flattened request bus
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // only the owner may be ready, and only while the FIFO has room
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_ready[i] = xfer && !out_fifo_full &&
                     (grant_idx == IDX_W'(i));
    end
  end

  assign fire    = xfer && sel_valid && !out_fifo_full;
  assign wd_inc  = xfer && !sel_valid && !out_fifo_full;
  assign wd_trip = wd_inc && (wd_cnt == WD_MAX);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next state: lock on a grant, release on last flit or watchdog
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (win_any) state_nxt = ST_XFER;
      ST_XFER: if ((fire && sel_last) || wd_trip)
                 state_nxt = ST_IDLE;
    endcase
  end

  // grant bookkeeping, output register and watchdog counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      grant_idx   <= '0;
      rr_ptr      <= PTR_RST;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      out_valid   <= fire;
      timeout_err <= wd_trip;
      if (fire) out_data <= sel_data;
      if (grant) begin
        grant_idx <= win_idx;
        rr_ptr    <= win_idx;
      end
      if (grant || fire || wd_trip) wd_cnt <= '0;
      else if (wd_inc)              wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_spine_output_arbiter.sv
// Directed bench for spine_output_arbiter with per-requester flit queues
// and an expected-output scoreboard.
module tb_spine_output_arbiter;

  localparam int NP = 11;
  localparam int DW = 16;
  localparam int IW = 4;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_last;
  logic [NP*DW-1:0]  req_data;
  logic [NP-1:0]     req_ready;
  logic              out_fifo_full;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic [IW-1:0]     grant_idx;
  logic              busy;
  logic              timeout_err;

  typedef struct packed {
    logic [3:0]  port;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [16:0] pq [NP][$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          last_ov = -1;
  bit          gap_on = 1'b0;
  logic [NP-1:0] acc;

  spine_output_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .out_fifo_full (out_fifo_full),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [16:0] f;
    for (int i = 0; i < NP; i++) begin
      if (pq[i].size() > 0) begin
        f = pq[i][0];
        req_valid[i] = 1'b1;
        req_last[i]  = f[16];
        req_data[i*DW +: DW] = f[15:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic load(int p, int n, logic [15:0] base, bit lastflag);
    exp_t e;
    logic l;
    for (int k = 0; k < n; k++) begin
      l = (k == n - 1) && lastflag;
      pq[p].push_back({l, base + 16'(k)});
      e.port = 4'(p);
      e.data = base + 16'(k);
      sb.push_back(e);
    end
  endtask

  task automatic clear_all();
    sb.delete();
    for (int i = 0; i < NP; i++) pq[i].delete();
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NP; i++)
      if (acc[i]) void'(pq[i].pop_front());
    chk("latency", {31'b0, out_valid}, {31'b0, |acc});
    if (out_valid) begin
      chk("sb_avail", {31'b0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("data", {16'b0, out_data}, {16'b0, e.data});
        chk("owner", {28'b0, grant_idx}, {28'b0, e.port});
      end
      if (gap_on && last_ov >= 0) chk("gap", cyc - last_ov, 32'd2);
      last_ov = cyc;
    end
    drive();
  endtask

  task automatic drain(string tag);
    for (int n = 0; n < 400 && sb.size() > 0; n++) tick();
    chk({tag, "_drain"}, sb.size(), 32'd0);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    out_fifo_full = 1'b0;
    clear_all();
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    last_ov = -1;
  endtask

  initial begin
    int n_to;
    bit saw_ready;
    bit saw_to;
    bit saw_idle;

    out_fifo_full = 1'b0;
    clear_all();
    drive();
    #12;
    chk("rst_out_data", {16'b0, out_data}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_grant", {28'b0, grant_idx}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_timeout", {31'b0, timeout_err}, 32'd0);
    chk("rst_ready", {21'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 1: three-flit packet from port 0
    load(0, 3, 16'hA001, 1'b1);
    drive();
    drain("t1");

    // 2: all ports, single-flit packets, round-robin order
    do_reset();
    gap_on = 1'b1;
    for (int p = 0; p < NP; p++) load(p, 1, 16'hB000 + 16'(p), 1'b1);
    load(0, 1, 16'hB0FF, 1'b1);
    drive();
    drain("t2");
    gap_on = 1'b0;

    // 3: backpressure for 100 cycles mid-packet on port 3
    load(3, 3, 16'h3001, 1'b1);
    drive();
    for (int n = 0; n < 20 && pq[3].size() == 3; n++) tick();
    chk("t3_head", pq[3].size(), 32'd2);
    out_fifo_full = 1'b1;
    saw_ready = 1'b0;
    saw_to = 1'b0;
    saw_idle = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      saw_ready |= req_ready[3];
      saw_to |= timeout_err;
      saw_idle |= !busy;
    end
    chk("t3_ready", {31'b0, saw_ready}, 32'd0);
    chk("t3_timeout", {31'b0, saw_to}, 32'd0);
    chk("t3_lock", {31'b0, saw_idle}, 32'd0);
    chk("t3_held", pq[3].size(), 32'd2);
    out_fifo_full = 1'b0;
    drain("t3");

    // 4: port 5 goes silent mid-packet, watchdog drops the lock
    load(5, 1, 16'h5001, 1'b0);
    drive();
    for (int n = 0; n < 20 && pq[5].size() != 0; n++) tick();
    chk("t4_head", pq[5].size(), 32'd0);
    load(6, 1, 16'h6001, 1'b1);
    drive();
    n_to = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      n_to++;
      if (timeout_err) break;
    end
    chk("t4_pulse", {31'b0, timeout_err}, 32'd1);
    chk("t4_when", n_to, TO);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    load(5, 1, 16'h5002, 1'b1);
    drive();
    tick();
    chk("t4_pulse_len", {31'b0, timeout_err}, 32'd0);
    drain("t4");

    // 5: rr_ptr parked at 4, then ports 2 and 7 compete
    load(4, 1, 16'h4001, 1'b1);
    drive();
    drain("t5a");
    load(7, 2, 16'h7001, 1'b1);
    load(2, 2, 16'h2001, 1'b1);
    drive();
    drain("t5");

    // 6: reset in the middle of a port 9 packet
    load(9, 3, 16'h9001, 1'b1);
    drive();
    for (int n = 0; n < 20 && pq[9].size() == 3; n++) tick();
    chk("t6_flowing", {31'b0, out_valid}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_ov", {31'b0, out_valid}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_grant", {28'b0, grant_idx}, 32'd0);
    clear_all();
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    last_ov = -1;
    load(0, 1, 16'h0003, 1'b1);
    load(5, 1, 16'h5003, 1'b1);
    drive();
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
